// File: rtl/mips_mem_arbiter.sv
// Shared memory-port arbiter for the mips_cpu core.
// Instruction fetch and data access compete for one Avalon-style memory port.
// Data wins contention. A starvation counter still lets instruction fetch through
// after STARVE_MAX back-to-back data grants.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transfer owned; arbitrate between pending requests
// BUS_I | instruction fetch on the memory port, held while waitrequest
// BUS_D | data read/write on the memory port, held while waitrequest
// RESP  | one-cycle valid pulse to the requester that just completed
module mips_mem_arbiter #(
    parameter int STARVE_MAX = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              i_stall,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_byteenable,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_rdata,
    input  logic              m_waitrequest,

    output logic              err
);

    // The counter never exceeds STARVE_MAX. The +2 keeps the width at least 1 bit
    // when STARVE_MAX is 0.
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;

    logic              m_read_q;
    logic              m_write_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [31:0]       m_wdata_q;
    logic [3:0]        m_byteenable_q;
    logic              i_valid_q;
    logic              d_valid_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              err_q;

    logic              d_pend;
    logic              starve_hit;
    logic              grant_i;
    logic              grant_d;

    // Arbitration decision, only acted upon in IDLE.
    always_comb begin
        d_pend     = d_read | d_write;
        starve_hit = (starve_q >= STARVE_LIM);
        grant_i    = i_req & (~d_pend | starve_hit);
        grant_d    = d_pend & ~grant_i;
    end

    // Starvation counter update: a data grant that makes a waiting fetch wait
    // again counts up. A fetch grant, or no fetch waiting, clears the counter.
    always_comb begin
        starve_d = starve_q;
        if (grant_i || !i_req) begin
            starve_d = '0;
        end else if (grant_d) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Arbiter FSM with registered memory strobes, valids and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            m_byteenable_q <= '0;
            i_valid_q      <= 1'b0;
            d_valid_q      <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            err_q          <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                    starve_q  <= starve_d;
                    if (d_read && d_write) begin
                        err_q <= 1'b1;
                    end
                    if (grant_i) begin
                        state_q        <= BUS_I;
                        m_read_q       <= 1'b1;
                        m_write_q      <= 1'b0;
                        m_addr_q       <= i_addr;
                        m_wdata_q      <= '0;
                        m_byteenable_q <= 4'b1111;
                    end else if (grant_d) begin
                        // A simultaneous read+write is issued as a write.
                        state_q        <= BUS_D;
                        m_read_q       <= d_read & ~d_write;
                        m_write_q      <= d_write;
                        m_addr_q       <= d_addr;
                        m_wdata_q      <= d_wdata;
                        m_byteenable_q <= d_byteenable;
                    end
                end
                BUS_I: begin
                    if (!m_waitrequest) begin
                        i_rdata_q <= m_rdata;
                        m_read_q  <= 1'b0;
                        i_valid_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                BUS_D: begin
                    if (!m_waitrequest) begin
                        if (!m_write_q) begin
                            d_rdata_q <= m_rdata;
                        end
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall is a raw request-pending indication and is released in the valid cycle.
    assign i_stall      = i_req & ~i_valid_q;
    assign d_stall      = d_pend & ~d_valid_q;

    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;
    assign m_byteenable = m_byteenable_q;
    assign i_valid      = i_valid_q;
    assign d_valid      = d_valid_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a vector table for single transfers and
// contention, plus hand sequences for starvation, wait states, error/freeze and async reset.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_rdata;
    logic        m_waitrequest;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mem_arbiter #(.STARVE_MAX(2), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_valid       (i_valid),
        .i_stall       (i_stall),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_byteenable  (d_byteenable),
        .d_rdata       (d_rdata),
        .d_valid       (d_valid),
        .d_stall       (d_stall),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_byteenable  (m_byteenable),
        .m_rdata       (m_rdata),
        .m_waitrequest (m_waitrequest),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] m_rdata;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_addr;
        logic        e_iv;
        logic        e_dv;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_is;
        logic        e_ds;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] mrd,
        input logic mr, input logic mw, input logic [31:0] ea,
        input logic iv, input logic dv, input logic [31:0] ird, input logic [31:0] drd,
        input logic is, input logic ds);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia; v.d_rd = dr; v.d_wr = dw; v.d_addr = da;
        v.m_rdata = mrd; v.e_mr = mr; v.e_mw = mw; v.e_addr = ea; v.e_iv = iv;
        v.e_dv = dv; v.e_ird = ird; v.e_drd = drd; v.e_is = is; v.e_ds = ds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[9];
    logic grants[6];
    logic exp_grants[6];
    int   got;
    int   mw_cycles;

    initial begin
        // Hand-computed vectors: inputs applied before the edge, outputs checked after it.
        vecs[0] = mk(1, 32'hBFC00000, 0, 0, 32'h0,    32'h8C020000, 1, 0, 32'hBFC00000, 0, 0, 32'h0,        32'h0,        1, 0);
        vecs[1] = mk(1, 32'hBFC00000, 0, 0, 32'h0,    32'h8C020000, 0, 0, 32'hBFC00000, 1, 0, 32'h8C020000, 32'h0,        0, 0);
        vecs[2] = mk(0, 32'hBFC00000, 0, 0, 32'h0,    32'h8C020000, 0, 0, 32'hBFC00000, 0, 0, 32'h8C020000, 32'h0,        0, 0);
        vecs[3] = mk(1, 32'hBFC00004, 1, 0, 32'h1000, 32'h11111111, 1, 0, 32'h1000,     0, 0, 32'h8C020000, 32'h0,        1, 1);
        vecs[4] = mk(1, 32'hBFC00004, 1, 0, 32'h1000, 32'h11111111, 0, 0, 32'h1000,     0, 1, 32'h8C020000, 32'h11111111, 1, 0);
        vecs[5] = mk(1, 32'hBFC00004, 0, 0, 32'h1000, 32'h11111111, 0, 0, 32'h1000,     0, 0, 32'h8C020000, 32'h11111111, 1, 0);
        vecs[6] = mk(1, 32'hBFC00004, 0, 0, 32'h1000, 32'h33333333, 1, 0, 32'hBFC00004, 0, 0, 32'h8C020000, 32'h11111111, 1, 0);
        vecs[7] = mk(1, 32'hBFC00004, 0, 0, 32'h1000, 32'h33333333, 0, 0, 32'hBFC00004, 1, 0, 32'h33333333, 32'h11111111, 0, 0);
        vecs[8] = mk(0, 32'hBFC00004, 0, 0, 32'h1000, 32'h33333333, 0, 0, 32'hBFC00004, 0, 0, 32'h33333333, 32'h11111111, 0, 0);
        exp_grants[0] = 0; exp_grants[1] = 0; exp_grants[2] = 1;
        exp_grants[3] = 0; exp_grants[4] = 0; exp_grants[5] = 1;

        // Reset state
        reset = 1'b0; clk_enable = 1'b1; i_req = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = 4'hF;
        m_rdata = '0; m_waitrequest = 1'b0;
        #2;
        chk("rst m_read", m_read, 0);
        chk("rst m_write", m_write, 0);
        chk("rst m_addr", m_addr, 0);
        chk("rst m_be", m_byteenable, 0);
        chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst err", err, 0);
        i_req = 1'b1;
        @(posedge clk); #1;
        chk("rst hold m_read", m_read, 0);
        chk("rst hold i_valid", i_valid, 0);
        @(negedge clk);
        i_req = 1'b0;
        reset = 1'b1;

        // Table: instruction-only fetch, then data/instruction contention
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            i_req = vecs[i].i_req; i_addr = vecs[i].i_addr;
            d_read = vecs[i].d_rd; d_write = vecs[i].d_wr; d_addr = vecs[i].d_addr;
            m_rdata = vecs[i].m_rdata;
            @(posedge clk); #1;
            chk($sformatf("vec%0d m_read", i),  m_read,  vecs[i].e_mr);
            chk($sformatf("vec%0d m_write", i), m_write, vecs[i].e_mw);
            chk($sformatf("vec%0d m_addr", i),  m_addr,  vecs[i].e_addr);
            chk($sformatf("vec%0d m_be", i),    m_byteenable, 4'hF);
            chk($sformatf("vec%0d i_valid", i), i_valid, vecs[i].e_iv);
            chk($sformatf("vec%0d d_valid", i), d_valid, vecs[i].e_dv);
            chk($sformatf("vec%0d i_rdata", i), i_rdata, vecs[i].e_ird);
            chk($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].e_drd);
            chk($sformatf("vec%0d i_stall", i), i_stall, vecs[i].e_is);
            chk($sformatf("vec%0d d_stall", i), d_stall, vecs[i].e_ds);
            chk($sformatf("vec%0d err", i),     err,     0);
        end

        // Starvation: both requesters held, expect D,D,I,D,D,I
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h400; d_read = 1'b1; d_addr = 32'h2000;
        m_rdata = 32'h55555555;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(posedge clk); #1;
            if (m_read) begin
                grants[got] = (m_addr == 32'h400);
                got++;
            end
        end
        chk("starve grant count", got, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < got) chk($sformatf("starve grant%0d is_instr", k), grants[k], exp_grants[k]);
        end
        // Requests dropped while the last fetch is on the bus; it must still complete.
        @(negedge clk);
        i_req = 1'b0; d_read = 1'b0;
        @(posedge clk); #1;
        chk("starve drop i_valid", i_valid, 1);
        chk("starve i_rdata", i_rdata, 32'h55555555);
        @(posedge clk); #1;
        chk("starve idle i_valid", i_valid, 0);
        chk("starve d_rdata", d_rdata, 32'h55555555);

        // Wait states on a data write
        @(negedge clk);
        d_write = 1'b1; d_wdata = 32'h22222222; d_byteenable = 4'b0011; d_addr = 32'h3000;
        m_waitrequest = 1'b1;
        #1;
        chk("ws idle d_stall", d_stall, 1);
        mw_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (m_write) mw_cycles++;
            chk($sformatf("ws%0d m_write", k), m_write, 1);
            chk($sformatf("ws%0d m_read", k),  m_read,  0);
            chk($sformatf("ws%0d d_stall", k), d_stall, 1);
            chk($sformatf("ws%0d d_valid", k), d_valid, 0);
            if (k == 0) begin
                chk("ws m_wdata", m_wdata, 32'h22222222);
                chk("ws m_be", m_byteenable, 4'b0011);
                chk("ws m_addr", m_addr, 32'h3000);
            end
        end
        m_waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("ws m_write cycles", mw_cycles, 4);
        chk("ws done m_write", m_write, 0);
        chk("ws done d_valid", d_valid, 1);
        chk("ws done d_stall", d_stall, 0);
        chk("ws write keeps d_rdata", d_rdata, 32'h55555555);
        @(negedge clk);
        d_write = 1'b0;
        @(posedge clk); #1;
        chk("ws idle d_valid", d_valid, 0);

        // Read+write conflict, then freeze mid-BUS
        @(negedge clk);
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h4000; d_wdata = 32'h66666666;
        d_byteenable = 4'hF; m_waitrequest = 1'b1; m_rdata = 32'h77777777;
        @(posedge clk); #1;
        chk("err m_write", m_write, 1);
        chk("err m_read", m_read, 0);
        chk("err flag", err, 1);
        chk("err m_addr", m_addr, 32'h4000);
        @(negedge clk);
        clk_enable = 1'b0; m_waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("frz%0d m_write", k), m_write, 1);
            chk($sformatf("frz%0d d_valid", k), d_valid, 0);
            chk($sformatf("frz%0d err", k), err, 1);
        end
        @(negedge clk);
        clk_enable = 1'b1;
        @(posedge clk); #1;
        chk("unfrz d_valid", d_valid, 1);
        chk("unfrz m_write", m_write, 0);
        @(negedge clk);
        d_read = 1'b0; d_write = 1'b0;
        @(posedge clk); #1;
        chk("err sticky", err, 1);
        chk("err d_valid", d_valid, 0);
        chk("err d_rdata", d_rdata, 32'h55555555);

        // Async reset mid-BUS_D
        @(negedge clk);
        d_read = 1'b1; d_addr = 32'h5000; m_waitrequest = 1'b1;
        @(posedge clk); #1;
        chk("ar bus m_read", m_read, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar m_read", m_read, 0);
        chk("ar m_addr", m_addr, 0);
        chk("ar err", err, 0);
        chk("ar d_rdata", d_rdata, 0);
        chk("ar i_rdata", i_rdata, 0);
        d_read = 1'b0;
        @(negedge clk);
        reset = 1'b1; m_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ar%0d d_valid", k), d_valid, 0);
            chk($sformatf("ar%0d m_read", k), m_read, 0);
        end
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h600; m_rdata = 32'h12345678;
        @(posedge clk); #1;
        chk("ar restart m_read", m_read, 1);
        chk("ar restart m_addr", m_addr, 32'h600);
        @(posedge clk); #1;
        chk("ar restart i_valid", i_valid, 1);
        chk("ar restart i_rdata", i_rdata, 32'h12345678);
        @(negedge clk);
        i_req = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
